// File: rtl/accum_pkg.sv
// Shared types and widths for the accumulator slice.
package accum_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage

// File: rtl/accum_16bit_adder.sv
// 16-bit unsigned adder; overflow is the carry out of the MSB.
module adder_16bit
    import accum_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    output logic [DATA_W-1:0] sum,
    output logic              overflow
);

    logic [DATA_W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
    end

    assign sum      = full[DATA_W-1:0];
    assign overflow = full[DATA_W];

endmodule

// File: rtl/accum_16bit.sv
// Streaming accumulator: sums NUM_SAMPLES samples through adder_16bit and
// holds the sum plus a sticky carry flag until acknowledged.
module accum_16bit
    import accum_pkg::*;
#(
    parameter int NUM_SAMPLES = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              sample_ready,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              overflow_flag,
    input  logic              result_ack,
    output logic              busy
);

    localparam int CNT_W = $clog2(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

    accum_state_t      state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    adder_16bit U_ADD (
        .a        (acc_q),
        .b        (sample),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    acc_d   = add_sum;
                    ovf_d   = ovf_q | add_ovf;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ack) begin
                    // ack together with start chains straight into a new run
                    if (start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sample_ready  = (state_q == ACCUM);
    assign busy          = (state_q == ACCUM);
    assign result_valid  = (state_q == DONE);
    assign result        = (state_q == DONE) ? acc_q : '0;
    assign overflow_flag = (state_q == DONE) ? ovf_q : 1'b0;

endmodule
